// File: rtl/video_pkg.sv
// Shared video definitions: colour-bit positions, default channel widths
// and a helper that computes the packed tone word width.
package video_pkg;

   localparam int COLOR_RED_BIT   = 0;
   localparam int COLOR_GREEN_BIT = 1;
   localparam int COLOR_BLUE_BIT  = 2;
   localparam int COLOR_W         = 3;

   localparam int DEF_RW = 3;
   localparam int DEF_GW = 3;
   localparam int DEF_BW = 2;

   // Width of the packed {blue, green, red} tone word.
   function automatic int toneWidth(input int rw, input int gw, input int bw);
      return rw + gw + bw;
   endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame-counted blink phase generator.
// A frame tick is a falling edge of vsync_i. The phase toggles once every
// BLINK_FRAMES ticks. Because it only moves on a tick, the phase is constant
// across a frame. With blink_en_i low, the counter is parked at zero and the
// phase reads as 1 (blinking layers shown). The forcing is combinational, so
// the very next pixel after the enable drops is already shown.
module blink_timer #(
   parameter int BLINK_FRAMES = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync_i,
   input  logic blink_en_i,
   output logic phase_o
);

   logic       vsyncPrev_q;
   logic [7:0] frameCount_q, frameCount_d;
   logic       phase_q, phase_d;
   logic       frameTick;

   // Detect the start of a frame and work out the next counter/phase values.
   always_comb begin
      frameTick    = vsyncPrev_q & ~vsync_i;
      frameCount_d = frameCount_q;
      phase_d      = phase_q;
      if (!blink_en_i) begin
         frameCount_d = 8'd0;
         phase_d      = 1'b1;
      end else if (frameTick) begin
         if (frameCount_q == 8'(BLINK_FRAMES - 1)) begin
            frameCount_d = 8'd0;
            phase_d      = ~phase_q;
         end else begin
            frameCount_d = frameCount_q + 8'd1;
         end
      end
   end

   // Hold previous vsync, the frame counter and the current phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsyncPrev_q  <= 1'b1;
         frameCount_q <= 8'd0;
         phase_q      <= 1'b1;
      end else begin
         vsyncPrev_q  <= vsync_i;
         frameCount_q <= frameCount_d;
         phase_q      <= phase_d;
      end
   end

   assign phase_o = phase_q | ~blink_en_i;

endmodule

// File: rtl/pixel_output_mixer.sv
// Final VGA pixel stage: priority layer select with per-layer blink,
// tone masking per channel, blanking, and 2-clock sync alignment.
module pixel_output_mixer
   import video_pkg::*;
#(
   parameter int RW           = DEF_RW,
   parameter int GW           = DEF_GW,
   parameter int BW           = DEF_BW,
   parameter int NLAYERS      = 2,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         blank_i,
   input  logic                         hsync_i,
   input  logic                         vsync_i,
   input  logic [NLAYERS-1:0]           layer_hit_i,
   input  logic [COLOR_W*NLAYERS-1:0]   layer_color_i,
   input  logic [NLAYERS-1:0]           layer_blink_i,
   input  logic [COLOR_W-1:0]           bg_color_i,
   input  logic [RW+GW+BW-1:0]          tone_i,
   input  logic                         blink_en_i,
   output logic [RW-1:0]                rojo_o,
   output logic [GW-1:0]                verde_o,
   output logic [BW-1:0]                azul_o,
   output logic                         hsync_o,
   output logic                         vsync_o
);

   localparam int TW = toneWidth(RW, GW, BW);

   logic               blinkPhase;
   logic [NLAYERS-1:0] layerVisible;
   logic [COLOR_W-1:0] selColor_d, selColor_q;
   logic [TW-1:0]      tone_q;
   logic               blank_q, hsync_q, vsync_q;
   logic [RW-1:0]      rojo_d, rojo_q;
   logic [GW-1:0]      verde_d, verde_q;
   logic [BW-1:0]      azul_d, azul_q;
   logic               hsyncOut_q, vsyncOut_q;

   blink_timer #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) uBlinkTimer (
      .clk       (clk),
      .rst_n     (rst_n),
      .vsync_i   (vsync_i),
      .blink_en_i(blink_en_i),
      .phase_o   (blinkPhase)
   );

   // Pick the lowest-index visible layer; the descending loop lets index 0 win.
   always_comb begin
      layerVisible = layer_hit_i & ~(layer_blink_i & {NLAYERS{~blinkPhase}});
      selColor_d   = bg_color_i;
      for (int k = NLAYERS - 1; k >= 0; k--) begin
         if (layerVisible[k]) begin
            selColor_d = layer_color_i[COLOR_W*k +: COLOR_W];
         end
      end
   end

   // Stage 1 register: chosen colour, tone, blank and syncs travel together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         selColor_q <= '0;
         tone_q     <= '0;
         blank_q    <= 1'b1;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
      end else begin
         selColor_q <= selColor_d;
         tone_q     <= tone_i;
         blank_q    <= blank_i;
         hsync_q    <= hsync_i;
         vsync_q    <= vsync_i;
      end
   end

   // Mask each tone field by its colour bit and force black while blanking.
   always_comb begin
      rojo_d  = '0;
      verde_d = '0;
      azul_d  = '0;
      if (!blank_q) begin
         if (selColor_q[COLOR_RED_BIT]) begin
            rojo_d = tone_q[RW-1:0];
         end
         if (selColor_q[COLOR_GREEN_BIT]) begin
            verde_d = tone_q[RW+GW-1:RW];
         end
         if (selColor_q[COLOR_BLUE_BIT]) begin
            azul_d = tone_q[TW-1:RW+GW];
         end
      end
   end

   // Stage 2 register: drive the DAC pins and the matching delayed syncs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rojo_q     <= '0;
         verde_q    <= '0;
         azul_q     <= '0;
         hsyncOut_q <= 1'b1;
         vsyncOut_q <= 1'b1;
      end else begin
         rojo_q     <= rojo_d;
         verde_q    <= verde_d;
         azul_q     <= azul_d;
         hsyncOut_q <= hsync_q;
         vsyncOut_q <= vsync_q;
      end
   end

   assign rojo_o  = rojo_q;
   assign verde_o = verde_q;
   assign azul_o  = azul_q;
   assign hsync_o = hsyncOut_q;
   assign vsync_o = vsyncOut_q;

endmodule

// File: tb/tb_pixel_output_mixer.sv
// Scoreboard bench for pixel_output_mixer: stimulus pushes model results,
// a negedge monitor pops and compares them when they fall due.
module tb_pixel_output_mixer;

   localparam int RW = 3;
   localparam int GW = 3;
   localparam int BW = 2;
   localparam int NL = 2;
   localparam int BF = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          blank_i = 1'b1;
   logic          hsync_i = 1'b1;
   logic          vsync_i = 1'b1;
   logic [NL-1:0] layer_hit_i = '0;
   logic [3*NL-1:0] layer_color_i = '0;
   logic [NL-1:0] layer_blink_i = '0;
   logic [2:0]    bg_color_i = '0;
   logic [7:0]    tone_i = '0;
   logic          blink_en_i = 1'b1;
   logic [RW-1:0] rojo_o;
   logic [GW-1:0] verde_o;
   logic [BW-1:0] azul_o;
   logic          hsync_o;
   logic          vsync_o;

   pixel_output_mixer #(
      .RW(RW), .GW(GW), .BW(BW), .NLAYERS(NL), .BLINK_FRAMES(BF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .blank_i      (blank_i),
      .hsync_i      (hsync_i),
      .vsync_i      (vsync_i),
      .layer_hit_i  (layer_hit_i),
      .layer_color_i(layer_color_i),
      .layer_blink_i(layer_blink_i),
      .bg_color_i   (bg_color_i),
      .tone_i       (tone_i),
      .blink_en_i   (blink_en_i),
      .rojo_o       (rojo_o),
      .verde_o      (verde_o),
      .azul_o       (azul_o),
      .hsync_o      (hsync_o),
      .vsync_o      (vsync_o)
   );

   // Free-running pixel clock.
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
      logic       hs;
      logic       vs;
   } exp_t;

   exp_t sb[$];
   int   edgeCount = 0;
   int   checks = 0;
   int   failures = 0;

   logic modelPrevVs = 1'b1;
   int   modelTicks = 0;

   // Count active edges so each expectation knows when it falls due.
   always @(posedge clk) edgeCount++;

   // Reference model: phase from frames counted since enable, first visible layer wins.
   task automatic applyStimulus(input logic [NL-1:0] hit, input logic [3*NL-1:0] col,
                                input logic [NL-1:0] blk, input logic [2:0] bg,
                                input logic [7:0] tone, input logic blank,
                                input logic hs, input logic vs, input logic en);
      exp_t       e;
      logic       phase;
      logic       found;
      logic [2:0] c;
      @(posedge clk);
      #2;
      layer_hit_i = hit; layer_color_i = col; layer_blink_i = blk;
      bg_color_i = bg; tone_i = tone; blank_i = blank;
      hsync_i = hs; vsync_i = vs; blink_en_i = en;
      phase = en ? (((modelTicks / BF) % 2) == 0) : 1'b1;
      c = bg;
      found = 1'b0;
      for (int k = 0; k < NL; k++) begin
         if (!found && hit[k] && !(blk[k] && !phase)) begin
            c = col[3*k +: 3];
            found = 1'b1;
         end
      end
      e.due = edgeCount + 2;
      e.r   = (blank || !c[0]) ? 3'd0 : tone[2:0];
      e.g   = (blank || !c[1]) ? 3'd0 : tone[5:3];
      e.b   = (blank || !c[2]) ? 2'd0 : tone[7:6];
      e.hs  = hs;
      e.vs  = vs;
      sb.push_back(e);
      if (!en) modelTicks = 0;
      else if (modelPrevVs && !vs) modelTicks++;
      modelPrevVs = vs;
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if ({rojo_o, verde_o, azul_o} !== {e.r, e.g, e.b}) begin
         failures++;
         $display("[TB] FAIL rgb edge=%0d got r=%0d g=%0d b=%0d want r=%0d g=%0d b=%0d",
                  e.due, rojo_o, verde_o, azul_o, e.r, e.g, e.b);
      end
      checks++;
      if ({hsync_o, vsync_o} !== {e.hs, e.vs}) begin
         failures++;
         $display("[TB] FAIL sync edge=%0d got hs=%b vs=%b want hs=%b vs=%b",
                  e.due, hsync_o, vsync_o, e.hs, e.vs);
      end
   endtask

   task automatic checkReset(input string tag);
      checks++;
      if ({rojo_o, verde_o, azul_o, hsync_o, vsync_o} !== 10'b00000000_11) begin
         failures++;
         $display("[TB] FAIL %s got r=%0d g=%0d b=%0d hs=%b vs=%b want 0 0 0 1 1",
                  tag, rojo_o, verde_o, azul_o, hsync_o, vsync_o);
      end
   endtask

   // Monitor: compare every expectation whose output edge has arrived.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= edgeCount) begin
         if (sb[0].due == edgeCount) checkOutput(sb[0]);
         void'(sb.pop_front());
      end
   end

   task automatic randomInputsInReset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         layer_hit_i = NL'($urandom); layer_color_i = (3*NL)'($urandom);
         layer_blink_i = NL'($urandom); bg_color_i = 3'($urandom);
         tone_i = 8'($urandom); blank_i = 1'($urandom);
         hsync_i = 1'($urandom); vsync_i = 1'($urandom); blink_en_i = 1'($urandom);
         @(negedge clk);
         checkReset("reset_hold");
      end
   endtask

   // One frame: vsync low on the first two pixels, both layers hit.
   task automatic blinkFrame(input logic en);
      for (int p = 0; p < 6; p++) begin
         applyStimulus(2'b11, {3'b010, 3'b001}, 2'b01, 3'b100, 8'hFF, 1'b0,
                       (p % 3) != 2, p >= 2, en);
      end
   endtask

   initial begin
      int frameLen;
      int pos;
      logic vsR;
      logic enR;

      $display("[TB] start");
      randomInputsInReset(4);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelPrevVs = 1'b1;
      modelTicks = 0;

      // Priority and background/blank corner pixels.
      applyStimulus(2'b11, {3'b110, 3'b001}, 2'b00, 3'b000, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(2'b10, {3'b110, 3'b001}, 2'b00, 3'b000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(2'b00, {3'b110, 3'b001}, 2'b00, 3'b101, 8'b10_011_101, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(2'b00, {3'b110, 3'b001}, 2'b00, 3'b101, 8'b10_011_101, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(2'b11, {3'b111, 3'b111}, 2'b11, 3'b111, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);

      // Blink over five frames, then drop enable inside a hidden frame and restore it.
      for (int f = 0; f < 5; f++) blinkFrame(1'b1);
      blinkFrame(1'b1);
      for (int p = 0; p < 3; p++)
         applyStimulus(2'b11, {3'b010, 3'b001}, 2'b01, 3'b100, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int f = 0; f < 4; f++) blinkFrame(1'b1);

      // Randomised traffic with realistic frame structure.
      frameLen = 10; pos = 0; enR = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if (pos == 0) begin
            frameLen = $urandom_range(6, 14);
            if ($urandom_range(0, 7) == 0) enR = ~enR;
         end
         vsR = (pos >= 2);
         applyStimulus(NL'($urandom), (3*NL)'($urandom), NL'($urandom), 3'($urandom),
                       8'($urandom), $urandom_range(0, 3) == 0, 1'($urandom), vsR, enR);
         pos = (pos + 1 >= frameLen) ? 0 : pos + 1;
      end

      // Reset in the middle of traffic: black and idle syncs at once.
      @(posedge clk);
      #3;
      sb.delete();
      rst_n = 1'b0;
      #1;
      checkReset("reset_async");
      randomInputsInReset(2);
      modelPrevVs = 1'b1;
      modelTicks = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(2'b01, {3'b000, 3'b011}, 2'b00, 3'b000, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(NL'($urandom), (3*NL)'($urandom), NL'($urandom), 3'($urandom),
                       8'($urandom), 1'($urandom), 1'($urandom), (i % 9) > 1, 1'b1);
      end

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain got pending=%0d want 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
